// File: rtl/branch_predictor_gshare_pkg.sv
// Shared encodings, default geometry and the counter update helper for the
// gshare branch predictor.
package branch_predictor_gshare_pkg;

   // Control-flow type of a resolved (and BTB-stored) instruction.
   typedef enum logic [1:0] {
      BP_COND = 2'b00,
      BP_JUMP = 2'b01,
      BP_CALL = 2'b10,
      BP_RET  = 2'b11
   } bp_type_e;

   // Default geometry.
   localparam int         BP_ADDR_W      = 32;
   localparam int         BP_BHT_ENTRIES = 256;
   localparam int         BP_BTB_ENTRIES = 64;
   localparam int         BP_GHR_W       = 8;
   localparam int         BP_RAS_DEPTH   = 8;
   localparam logic [1:0] BP_CTR_INIT    = 2'b01;  // weakly not-taken

   // 2-bit saturating counter step: 3 holds on taken, 0 holds on not-taken.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken && ctr != 2'b11) begin
         nxt = ctr + 2'b01;
      end else if (!taken && ctr != 2'b00) begin
         nxt = ctr - 2'b01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predictor_gshare_ras.sv
// Return address stack: circular buffer with a write pointer and an occupancy
// count. A push while full overwrites the oldest entry; a pop while empty is
// ignored. The top of stack is always the entry just below the pointer.
module branch_predictor_gshare_ras
   import branch_predictor_gshare_pkg::*;
#(
   parameter int ADDR_W = BP_ADDR_W,
   parameter int DEPTH  = BP_RAS_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] push_data_i,
   output logic [ADDR_W-1:0] top_o,
   output logic              empty_o,
   output logic              full_o
);

   localparam int PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] stack_q [DEPTH];
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW:0]       cnt_q, cnt_d;
   logic              wr_en;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign top_o   = stack_q[ptr_q - PW'(1)];

   // Next pointer/count: push always advances (wrapping onto the oldest), pop only when non-empty.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      wr_en = 1'b0;
      if (push_i) begin
         wr_en = 1'b1;
         ptr_d = ptr_q + PW'(1);
         if (!full_o) begin
            cnt_d = cnt_q + (PW+1)'(1);
         end
      end else if (pop_i && !empty_o) begin
         ptr_d = ptr_q - PW'(1);
         cnt_d = cnt_q - (PW+1)'(1);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Stack storage; cleared on reset so a stale return never looks valid after power-up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else if (wr_en) begin
         stack_q[ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/branch_predictor_gshare.sv
// IF-stage next-PC predictor: gshare-indexed 2-bit BHT, direct-mapped typed
// BTB and a return address stack. Prediction is purely combinational from the
// fetch PC; every table is trained from the single EX resolution port. History
// is non-speculative, so each resolution carries the history used at fetch to
// train exactly the counter that produced the prediction.
module branch_predictor_gshare
   import branch_predictor_gshare_pkg::*;
#(
   parameter int         ADDR_W      = BP_ADDR_W,
   parameter int         BHT_ENTRIES = BP_BHT_ENTRIES,
   parameter int         BTB_ENTRIES = BP_BTB_ENTRIES,
   parameter int         GHR_W       = BP_GHR_W,
   parameter int         RAS_DEPTH   = BP_RAS_DEPTH,
   parameter logic [1:0] CTR_INIT    = BP_CTR_INIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [ADDR_W-1:0] pred_npc_o,
   output logic              pred_taken_o,
   output logic [GHR_W-1:0]  pred_ghr_o,
   input  logic              upd_valid_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   input  logic [ADDR_W-1:0] upd_target_i,
   input  logic              upd_taken_i,
   input  logic [1:0]        upd_type_i,
   input  logic [GHR_W-1:0]  upd_ghr_i
);

   localparam int BHT_IW = $clog2(BHT_ENTRIES);
   localparam int BTB_IW = $clog2(BTB_ENTRIES);
   localparam int TAG_W  = ADDR_W - BTB_IW - 2;

   // History occupies the top GHR_W bits of the BHT index.
   function automatic logic [BHT_IW-1:0] bht_index(input logic [ADDR_W-1:0] pc,
                                                   input logic [GHR_W-1:0]  ghr);
      logic [BHT_IW-1:0] hist;
      hist = BHT_IW'(ghr) << (BHT_IW - GHR_W);
      return pc[BHT_IW+1:2] ^ hist;
   endfunction

   // Tables and history.
   logic [1:0]        bht_q        [BHT_ENTRIES];
   logic              btb_valid_q  [BTB_ENTRIES];
   logic [TAG_W-1:0]  btb_tag_q    [BTB_ENTRIES];
   logic [ADDR_W-1:0] btb_target_q [BTB_ENTRIES];
   bp_type_e          btb_type_q   [BTB_ENTRIES];
   logic [GHR_W-1:0]  ghr_q, ghr_d;

   // Fetch-side lookup.
   logic [BHT_IW-1:0] f_bidx;
   logic [BTB_IW-1:0] f_tidx;
   logic [TAG_W-1:0]  f_tag;
   logic              f_hit;
   logic [ADDR_W-1:0] f_npc;
   logic              f_taken;

   // Resolution-side training.
   logic [BHT_IW-1:0] u_bidx;
   logic [BTB_IW-1:0] u_tidx;
   logic [TAG_W-1:0]  u_tag;
   logic              u_hit;
   logic              u_is_cond;
   logic [1:0]        bht_d;
   logic              btb_we;
   bp_type_e          u_type;

   // Return stack hookup.
   logic              ras_push, ras_pop;
   logic [ADDR_W-1:0] ras_push_data, ras_top;
   logic              ras_empty;
   logic              ras_full_unused;
   logic [3:0]        pc_lsb_unused;

   assign pc_lsb_unused = {pc_i[1:0], upd_pc_i[1:0]};

   // Predict: BTB hit + type selects the redirect, everything else falls through to pc+4.
   always_comb begin
      f_bidx  = bht_index(pc_i, ghr_q);
      f_tidx  = pc_i[BTB_IW+1:2];
      f_tag   = pc_i[ADDR_W-1:BTB_IW+2];
      f_hit   = btb_valid_q[f_tidx] && (btb_tag_q[f_tidx] == f_tag);
      f_npc   = pc_i + ADDR_W'(4);
      f_taken = 1'b0;
      if (f_hit) begin
         case (btb_type_q[f_tidx])
            BP_COND: begin
               if (bht_q[f_bidx][1]) begin
                  f_taken = 1'b1;
                  f_npc   = btb_target_q[f_tidx];
               end
            end
            BP_JUMP, BP_CALL: begin
               f_taken = 1'b1;
               f_npc   = btb_target_q[f_tidx];
            end
            BP_RET: begin
               if (!ras_empty) begin
                  f_taken = 1'b1;
                  f_npc   = ras_top;
               end
            end
            default: ;
         endcase
      end
      pred_npc_o   = rst ? '0 : f_npc;
      pred_taken_o = rst ? 1'b0 : f_taken;
      pred_ghr_o   = rst ? '0 : ghr_q;
   end

   // Train: decode which tables the resolved instruction touches and their new contents.
   always_comb begin
      u_type        = bp_type_e'(upd_type_i);
      u_bidx        = bht_index(upd_pc_i, upd_ghr_i);
      u_tidx        = upd_pc_i[BTB_IW+1:2];
      u_tag         = upd_pc_i[ADDR_W-1:BTB_IW+2];
      u_hit         = btb_valid_q[u_tidx] && (btb_tag_q[u_tidx] == u_tag);
      u_is_cond     = upd_valid_i && (u_type == BP_COND);
      bht_d         = ctr_step(bht_q[u_bidx], upd_taken_i);
      ghr_d         = u_is_cond ? GHR_W'({ghr_q, upd_taken_i}) : ghr_q;
      btb_we        = upd_valid_i && upd_taken_i &&
                      (!u_hit || (btb_target_q[u_tidx] != upd_target_i) ||
                       (btb_type_q[u_tidx] != u_type));
      ras_push      = upd_valid_i && (u_type == BP_CALL);
      ras_pop       = upd_valid_i && (u_type == BP_RET);
      ras_push_data = upd_pc_i + ADDR_W'(4);
   end

   // BHT counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= CTR_INIT;
         end
      end else if (u_is_cond) begin
         bht_q[u_bidx] <= bht_d;
      end
   end

   // Global history register, advanced only by resolved conditionals.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   // BTB lines; rewritten only when a taken resolution disagrees with what is stored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_q[i]  <= 1'b0;
            btb_tag_q[i]    <= '0;
            btb_target_q[i] <= '0;
            btb_type_q[i]   <= BP_COND;
         end
      end else if (btb_we) begin
         btb_valid_q[u_tidx]  <= 1'b1;
         btb_tag_q[u_tidx]    <= u_tag;
         btb_target_q[u_tidx] <= upd_target_i;
         btb_type_q[u_tidx]   <= u_type;
      end
   end

   branch_predictor_gshare_ras #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst         (rst),
      .push_i      (ras_push),
      .pop_i       (ras_pop),
      .push_data_i (ras_push_data),
      .top_o       (ras_top),
      .empty_o     (ras_empty),
      .full_o      (ras_full_unused)
   );

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for the gshare predictor: reset, conditional training and
// saturation, typed call/return prediction, RAS overflow and mid-update reset.
module tb_branch_predictor_gshare;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic [31:0] pred_npc_o;
   logic        pred_taken_o;
   logic [7:0]  pred_ghr_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic [31:0] upd_target_i;
   logic        upd_taken_i;
   logic [1:0]  upd_type_i;
   logic [7:0]  upd_ghr_i;

   int n_vec = 0;
   int n_err = 0;

   branch_predictor_gshare dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .pred_npc_o   (pred_npc_o),
      .pred_taken_o (pred_taken_o),
      .pred_ghr_o   (pred_ghr_o),
      .upd_valid_i  (upd_valid_i),
      .upd_pc_i     (upd_pc_i),
      .upd_target_i (upd_target_i),
      .upd_taken_i  (upd_taken_i),
      .upd_type_i   (upd_type_i),
      .upd_ghr_i    (upd_ghr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                        input logic taken, input logic [7:0] ghr);
      @(negedge clk);
      pc_i = pc;
      #1;
      $display("fetch %s pc=0x%0h npc=0x%0h taken=%0b ghr=0x%0h", tag, pc, pred_npc_o, pred_taken_o, pred_ghr_o);
      chk({tag, "_npc"}, pred_npc_o, npc);
      chk({tag, "_taken"}, 32'(pred_taken_o), 32'(taken));
      chk({tag, "_ghr"}, 32'(pred_ghr_o), 32'(ghr));
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                      input logic [1:0] typ, input logic [7:0] ghr);
      @(negedge clk);
      upd_valid_i  = 1'b1;
      upd_pc_i     = pc;
      upd_target_i = tgt;
      upd_taken_i  = taken;
      upd_type_i   = typ;
      upd_ghr_i    = ghr;
      @(posedge clk);
      #1;
      upd_valid_i = 1'b0;
      $display("update pc=0x%0h tgt=0x%0h taken=%0b type=%0d ghr=0x%0h", pc, tgt, taken, typ, ghr);
   endtask

   function automatic int bht_not_init();
      int bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (dut.bht_q[i] !== 2'b01) bad++;
      end
      return bad;
   endfunction

   function automatic int btb_valid_count();
      int n = 0;
      for (int i = 0; i < 64; i++) begin
         if (dut.btb_valid_q[i] !== 1'b0) n++;
      end
      return n;
   endfunction

   initial begin
      rst          = 1'b1;
      pc_i         = 32'h100;
      upd_valid_i  = 1'b0;
      upd_pc_i     = '0;
      upd_target_i = '0;
      upd_taken_i  = 1'b0;
      upd_type_i   = 2'b00;
      upd_ghr_i    = '0;

      // 1. Reset: outputs forced low, then fall-through prediction, all counters weakly not-taken.
      #12;
      chk("rst_npc", pred_npc_o, 32'h0);
      chk("rst_taken", 32'(pred_taken_o), 32'h0);
      chk("rst_ghr", 32'(pred_ghr_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      fetch("reset_fetch", 32'h100, 32'h104, 1'b0, 8'h00);
      chk("bht_all_01", 32'(bht_not_init()), 32'h0);
      chk("btb_none_valid", 32'(btb_valid_count()), 32'h0);

      // 2. Two taken conditionals at 0x200 trained with ghr=0 -> counter 0x80 goes 01->10->11.
      upd(32'h200, 32'h280, 1'b1, 2'b00, 8'h00);
      chk("ctr80_after1", 32'(dut.bht_q[8'h80]), 32'h2);
      upd(32'h200, 32'h280, 1'b1, 2'b00, 8'h00);
      chk("ctr80_after2", 32'(dut.bht_q[8'h80]), 32'h3);
      // Live ghr=3 indexes counter 0x83 (still 01) -> fall through.
      fetch("cond_ghr3", 32'h200, 32'h204, 1'b0, 8'h03);
      // Saturate at 3.
      upd(32'h200, 32'h280, 1'b1, 2'b00, 8'h00);
      chk("ctr80_sat3", 32'(dut.bht_q[8'h80]), 32'h3);
      // Train the counter the live history will use (0x80^0x0F=0x8F) -> predict taken.
      upd(32'h200, 32'h280, 1'b1, 2'b00, 8'h0F);
      fetch("cond_taken", 32'h200, 32'h280, 1'b1, 8'h0F);

      // 3. Four not-taken updates: 11->10->01->00->00, BTB line kept.
      upd(32'h200, 32'h280, 1'b0, 2'b00, 8'h00);
      upd(32'h200, 32'h280, 1'b0, 2'b00, 8'h00);
      upd(32'h200, 32'h280, 1'b0, 2'b00, 8'h00);
      chk("ctr80_zero", 32'(dut.bht_q[8'h80]), 32'h0);
      upd(32'h200, 32'h280, 1'b0, 2'b00, 8'h00);
      chk("ctr80_sat0", 32'(dut.bht_q[8'h80]), 32'h0);
      chk("btb0_valid", 32'(dut.btb_valid_q[0]), 32'h1);
      chk("btb0_target", dut.btb_target_q[0], 32'h280);
      fetch("cond_nt_ghrF0", 32'h200, 32'h204, 1'b0, 8'hF0);

      // 4. Return typed in BTB (pop on empty is a no-op), then a call pushes 0x304.
      upd(32'h410, 32'h304, 1'b1, 2'b11, 8'h00);
      fetch("ret_empty0", 32'h410, 32'h414, 1'b0, 8'hF0);
      upd(32'h300, 32'h400, 1'b1, 2'b10, 8'h00);
      fetch("call_hit", 32'h300, 32'h400, 1'b1, 8'hF0);
      fetch("ret_pred", 32'h410, 32'h304, 1'b1, 8'hF0);
      upd(32'h410, 32'h304, 1'b1, 2'b11, 8'h00);
      fetch("ret_empty1", 32'h410, 32'h414, 1'b0, 8'hF0);
      upd(32'h410, 32'h304, 1'b1, 2'b11, 8'h00);
      fetch("ret_empty2", 32'h410, 32'h414, 1'b0, 8'hF0);

      // 5. RAS overflow: return line at 0x2008, nine calls, eight pops newest first, ninth misses.
      upd(32'h2008, 32'h1084, 1'b1, 2'b11, 8'h00);
      for (int k = 0; k < 9; k++) begin
         upd(32'h1000 + 32'(16 * k), 32'h5000, 1'b1, 2'b10, 8'h00);
      end
      chk("ras_cnt_sat", 32'(dut.u_ras.cnt_q), 32'h8);
      for (int k = 0; k < 8; k++) begin
         fetch($sformatf("ras_pop%0d", k), 32'h2008, 32'h1084 - 32'(16 * k), 1'b1, 8'hF0);
         upd(32'h2008, 32'h1084, 1'b1, 2'b11, 8'h00);
      end
      fetch("ras_drained", 32'h2008, 32'h200C, 1'b0, 8'hF0);

      // 6. Reset raised while an update is presented: update dropped, everything back to reset.
      upd(32'h1000, 32'h5000, 1'b1, 2'b10, 8'h00);
      @(negedge clk);
      upd_valid_i  = 1'b1;
      upd_pc_i     = 32'h200;
      upd_target_i = 32'h280;
      upd_taken_i  = 1'b1;
      upd_type_i   = 2'b00;
      upd_ghr_i    = 8'h00;
      pc_i         = 32'h2008;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_npc", pred_npc_o, 32'h0);
      chk("midrst_taken", 32'(pred_taken_o), 32'h0);
      chk("midrst_ghr", 32'(pred_ghr_o), 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      upd_valid_i = 1'b0;
      rst = 1'b0;
      $display("reset pulse during update released");
      chk("post_bht_all_01", 32'(bht_not_init()), 32'h0);
      chk("post_btb_none", 32'(btb_valid_count()), 32'h0);
      chk("post_ras_cnt", 32'(dut.u_ras.cnt_q), 32'h0);
      fetch("post_reset", 32'h100, 32'h104, 1'b0, 8'h00);
      fetch("post_ret_miss", 32'h2008, 32'h200C, 1'b0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
